dmem_arbiter: RTL

//  Two-requester arbiter/sequencer in front of the single-port byte-addressed data memory.

---
 rtl/dmem_arb_pkg.sv | 34 +++
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_rr_pick.sv | 12 +
 rtl/dmem_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-requester data-memory arbiter.
// The alignment rule below is only consulted when DMEM_ARB_ALIGN_CHECK_EN is defined.
package dmem_arb_pkg;

   localparam int ARB_ADDR_W = 10;
   localparam int ARB_DATA_W = 32;

   localparam logic [1:0] DT_WORD = 2'd0;
   localparam logic [1:0] DT_HALF = 2'd1;
   localparam logic [1:0] DT_BYTE = 2'd2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic [1:0]            dtype;
      logic                  owner;
   } cmd_t;

   // Type 3 is treated as a word, matching the memory's decode.
   function automatic logic misaligned(input logic [1:0] dtype, input logic [1:0] a);
      case (dtype)
         DT_HALF: return a[0];
         DT_BYTE: return 1'b0;
         default: return (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory command/return bus.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              r0_req, r0_we, r0_gnt, r0_rsp_valid, r0_err;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata, r0_rdata;
   logic [1:0]        r0_type;

   logic              r1_req, r1_we, r1_gnt, r1_rsp_valid, r1_err;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata, r1_rdata;
   logic [1:0]        r1_type;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_read, mem_write;
   logic [1:0]        mem_type;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r0_type,
      input  r1_req, r1_we, r1_addr, r1_wdata, r1_type,
      output r0_gnt, r0_rsp_valid, r0_rdata, r0_err,
      output r1_gnt, r1_rsp_valid, r1_rdata, r1_err,
      output mem_addr, mem_wdata, mem_read, mem_write, mem_type,
      input  mem_rdata
   );

   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r0_type,
      output r1_req, r1_we, r1_addr, r1_wdata, r1_type,
      input  r0_gnt, r0_rsp_valid, r0_rdata, r0_err,
      input  r1_gnt, r1_rsp_valid, r1_rdata, r1_err,
      input  mem_addr, mem_wdata, mem_read, mem_write, mem_type,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module dmem_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = req;
      if (&req) gnt = last ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-port data memory.
// Define DMEM_ARB_ALIGN_CHECK_EN to suppress and flag misaligned word/half accesses.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);

   logic [1:0]        req, gnt, rsp_vld_p2, err_p2;
   logic              last, xfer, bad;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] rdata_p2 [2];
   cmd_t              cmd_in, cmd_p1;
   state_t            state, state_nxt;

   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d, input logic [1:0] t);
      case (t)
         DT_HALF: return {{(DATA_W-16){1'b0}}, d[15:0]};
         DT_BYTE: return {{(DATA_W-8){1'b0}}, d[7:0]};
         default: return d;
      endcase
   endfunction

   assign req = {bus.r1_req, bus.r0_req};

   dmem_rr_pick u_pick (
      .req  (req),
      .last (last),
      .gnt  (gnt)
   );

   assign bus.r0_gnt = gnt[0];
   assign bus.r1_gnt = gnt[1];
   assign xfer       = |(req & gnt);
   assign addr_sel   = gnt[1] ? bus.r1_addr : bus.r0_addr;

   always_comb begin
      cmd_in       = '0;
      cmd_in.owner = gnt[1];
      cmd_in.addr  = addr_sel;
      if (gnt[1]) begin
         cmd_in.we    = bus.r1_we;
         cmd_in.wdata = bus.r1_wdata;
         cmd_in.dtype = bus.r1_type;
      end else begin
         cmd_in.we    = bus.r0_we;
         cmd_in.wdata = bus.r0_wdata;
         cmd_in.dtype = bus.r0_type;
      end
   end

   // Stage p1: command register, loaded on every accepted transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_p1 <= '0;
         last   <= 1'b1;
      end else if (xfer) begin
         cmd_p1 <= cmd_in;
         last   <= cmd_in.owner;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign bad = misaligned(cmd_p1.dtype, cmd_p1.addr[1:0]);
`else
   assign bad = 1'b0;
`endif

   // Strobes come straight from the state so an async reset kills a write mid-cycle.
   always_comb begin
      state_nxt     = xfer ? ST_ACCESS : ST_IDLE;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      if (state == ST_ACCESS && !bad) begin
         bus.mem_read  = ~cmd_p1.we;
         bus.mem_write = cmd_p1.we;
      end
   end

   assign bus.mem_addr  = cmd_p1.addr;
   assign bus.mem_wdata = cmd_p1.wdata;
   assign bus.mem_type  = cmd_p1.dtype;

   // Stage p2: response to the owner of the access just completed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld_p2  <= '0;
         err_p2      <= '0;
         rdata_p2[0] <= '0;
         rdata_p2[1] <= '0;
      end else begin
         rsp_vld_p2 <= '0;
         if (state == ST_ACCESS) begin
            rsp_vld_p2[cmd_p1.owner] <= 1'b1;
            err_p2[cmd_p1.owner]     <= bad;
            if (!cmd_p1.we && !bad)
               rdata_p2[cmd_p1.owner] <= extend(bus.mem_rdata, cmd_p1.dtype);
         end
      end
   end

   assign bus.r0_rsp_valid = rsp_vld_p2[0];
   assign bus.r1_rsp_valid = rsp_vld_p2[1];
   assign bus.r0_rdata     = rdata_p2[0];
   assign bus.r1_rdata     = rdata_p2[1];
   assign bus.r0_err       = err_p2[0];
   assign bus.r1_err       = err_p2[1];

endmodule
